palette_lut_banked: RTL and testbench

- Parametrised, writable colour-palette lookup for the VGA pixel path. Maps a per-pixel colour index plus bank select to RGB.
- Adds runtime palette rewrites and a frame-timed global fade-to-black / fade-from-black brightness scaler.
- Sits between the sprite/background index mux and the VGA output registers, replacing per-screen constant palettes.

---
 rtl/palette_pkg.sv | 17 +
 rtl/palette_fade_ctrl.sv | 42 ++++
 rtl/palette_lut_banked.sv | 75 +++++++
 tb/tb_palette_lut_banked.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// palette_pkg: shared types, defaults and the power-on palette for palette_lut_banked.
package palette_pkg;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_COMP_W = 4;
  localparam int DEF_BANKS = 4;
  localparam logic [4:0] LEVEL_MAX = 5'd16;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  typedef enum logic [1:0] {BRIGHT, DARK, FADING_OUT, FADING_IN} fade_state_e;
  localparam rgb_t DEFAULT_PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };
endpackage

// File: rtl/palette_fade_ctrl.sv
// palette_fade_ctrl: frame-stepped fade FSM producing the global brightness level.
module palette_fade_ctrl
  import palette_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fade_start,
  input  logic       fade_dir,
  output logic [4:0] level,
  output logic       busy
);
  fade_state_e state, state_nx;
  logic [4:0] level_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BRIGHT;
      level <= LEVEL_MAX;
    end else begin
      state <= state_nx;
      level <= level_nx;
    end
  // Starting a fade never steps the level; the first step waits for the next tick.
  always_comb begin
    state_nx = state;
    level_nx = level;
    case (state)
      BRIGHT: state_nx = (fade_start && !fade_dir) ? FADING_OUT : BRIGHT;
      DARK: state_nx = (fade_start && fade_dir) ? FADING_IN : DARK;
      FADING_OUT: if (frame_tick) begin
        level_nx = level - 5'd1;
        state_nx = (level == 5'd1) ? DARK : FADING_OUT;
      end
      FADING_IN: if (frame_tick) begin
        level_nx = level + 5'd1;
        state_nx = (level == LEVEL_MAX - 5'd1) ? BRIGHT : FADING_IN;
      end
      default: state_nx = BRIGHT;
    endcase
  end
  assign busy = (state == FADING_OUT) || (state == FADING_IN);
endmodule

// File: rtl/palette_lut_banked.sv
// palette_lut_banked: banked writable palette lookup with a two-stage pipeline and global fade scaling.
module palette_lut_banked
  import palette_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int BANKS = DEF_BANKS,
  parameter int COMP_W = DEF_COMP_W,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int RGB_W = 3 * COMP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid_i,
  input  logic [BANK_W-1:0] pix_bank_i,
  input  logic [IDX_W-1:0]  pix_idx_i,
  output logic              pix_valid_o,
  output logic [COMP_W-1:0] red_o,
  output logic [COMP_W-1:0] green_o,
  output logic [COMP_W-1:0] blue_o,
  input  logic              wr_en_i,
  input  logic [BANK_W-1:0] wr_bank_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [RGB_W-1:0]  wr_rgb_i,
  input  logic              frame_tick_i,
  input  logic              fade_start_i,
  input  logic              fade_dir_i,
  output logic              fade_busy_o,
  output logic [4:0]        level_o
);
  localparam int ENTRIES = 2 ** IDX_W;
  logic [RGB_W-1:0] mem [BANKS][ENTRIES];
  logic [RGB_W-1:0] s1_rgb;
  logic s1_valid;
  function automatic logic [COMP_W-1:0] scale(input logic [COMP_W-1:0] c, input logic [4:0] l);
    logic [COMP_W+4:0] p;
    p = (COMP_W + 5)'(c) * (COMP_W + 5)'(l);
    return p[COMP_W+3:4];
  endfunction
  palette_fade_ctrl u_fade (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick_i),
    .fade_start(fade_start_i),
    .fade_dir  (fade_dir_i),
    .level     (level_o),
    .busy      (fade_busy_o)
  );
  // Stage 1 samples the array before this cycle's write lands, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++)
        for (int i = 0; i < ENTRIES; i++)
          mem[b][i] <= RGB_W'(DEFAULT_PALETTE[4'(i)]);
      s1_rgb <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (wr_en_i) mem[wr_bank_i][wr_idx_i] <= wr_rgb_i;
      s1_rgb <= mem[pix_bank_i][pix_idx_i];
      s1_valid <= pix_valid_i;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pix_valid_o <= 1'b0;
      red_o <= '0;
      green_o <= '0;
      blue_o <= '0;
    end else begin
      pix_valid_o <= s1_valid;
      if (s1_valid) begin
        red_o <= scale(s1_rgb[3*COMP_W-1:2*COMP_W], level_o);
        green_o <= scale(s1_rgb[2*COMP_W-1:COMP_W], level_o);
        blue_o <= scale(s1_rgb[COMP_W-1:0], level_o);
      end
    end
endmodule

// File: tb/tb_palette_lut_banked.sv
// tb_palette_lut_banked: vector table plus scoreboard checks of lookup, writes and fades.
module tb_palette_lut_banked;
  logic clk = 0, rst_n = 0;
  logic pix_valid_i = 0, wr_en_i = 0, frame_tick_i = 0, fade_start_i = 0, fade_dir_i = 0;
  logic [1:0] pix_bank_i = 0, wr_bank_i = 0;
  logic [3:0] pix_idx_i = 0, wr_idx_i = 0;
  logic [11:0] wr_rgb_i = 0;
  logic pix_valid_o, fade_busy_o;
  logic [3:0] red_o, green_o, blue_o;
  logic [4:0] level_o;
  int checks = 0, failures = 0;
  logic [11:0] sb [$];
  typedef struct {
    logic [1:0] bank;
    logic [3:0] idx;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs [6];

  palette_lut_banked dut (
    .clk(clk), .rst_n(rst_n), .pix_valid_i(pix_valid_i), .pix_bank_i(pix_bank_i),
    .pix_idx_i(pix_idx_i), .pix_valid_o(pix_valid_o), .red_o(red_o), .green_o(green_o),
    .blue_o(blue_o), .wr_en_i(wr_en_i), .wr_bank_i(wr_bank_i), .wr_idx_i(wr_idx_i),
    .wr_rgb_i(wr_rgb_i), .frame_tick_i(frame_tick_i), .fade_start_i(fade_start_i),
    .fade_dir_i(fade_dir_i), .fade_busy_o(fade_busy_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && pix_valid_o) begin
      if (sb.size() == 0) check("unexpected_pixel", 1, 0);
      else check("pixel_rgb", {20'h0, red_o, green_o, blue_o}, {20'h0, sb.pop_front()});
    end

  task automatic pix(input logic [1:0] b, input logic [3:0] i, input logic [11:0] exp);
    pix_valid_i = 1; pix_bank_i = b; pix_idx_i = i;
    sb.push_back(exp);
    @(negedge clk);
    pix_valid_i = 0;
  endtask

  task automatic flush();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick_i = 1;
      @(negedge clk);
      frame_tick_i = 0;
    end
  endtask

  task automatic start(input logic dir);
    fade_start_i = 1; fade_dir_i = dir;
    @(negedge clk);
    fade_start_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'd0, 4'd1, 12'h00A};
    vecs[1] = '{2'd0, 4'd0, 12'h000};
    vecs[2] = '{2'd3, 4'd15, 12'hFFF};
    vecs[3] = '{2'd1, 4'd7, 12'hAAA};
    vecs[4] = '{2'd2, 4'd12, 12'hF55};
    vecs[5] = '{2'd3, 4'd9, 12'h55F};
    repeat (2) @(negedge clk);
    check("rst_valid", pix_valid_o, 0);
    check("rst_rgb", {red_o, green_o, blue_o}, 0);
    check("rst_level", level_o, 16);
    check("rst_busy", fade_busy_o, 0);
    rst_n = 1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) pix(vecs[k].bank, vecs[k].idx, vecs[k].exp);
    flush();
    check("rgb_hold_invalid", {red_o, green_o, blue_o}, 12'h55F);
    // write then read next cycle; other bank keeps its default
    wr_en_i = 1; wr_bank_i = 2; wr_idx_i = 5; wr_rgb_i = 12'hA3C;
    @(negedge clk);
    wr_en_i = 0;
    pix(2, 5, 12'hA3C);
    pix(0, 5, 12'hA0A);
    flush();
    // same-cycle write and read returns the old entry
    wr_en_i = 1; wr_bank_i = 1; wr_idx_i = 3; wr_rgb_i = 12'hFFF;
    pix(1, 3, 12'h0AA);
    wr_en_i = 0;
    pix(1, 3, 12'hFFF);
    flush();
    // fade-in request while bright is ignored
    start(1);
    check("bright_fadein_busy", fade_busy_o, 0);
    check("bright_fadein_level", level_o, 16);
    wr_en_i = 1; wr_bank_i = 0; wr_idx_i = 2; wr_rgb_i = 12'hF82;
    @(negedge clk);
    wr_en_i = 0;
    start(0);
    check("fadeout_busy", fade_busy_o, 1);
    check("fadeout_level_start", level_o, 16);
    ticks(4);
    check("fadeout_level4", level_o, 12);
    start(1);
    check("fadeout_ignored_start_busy", fade_busy_o, 1);
    check("fadeout_ignored_start_level", level_o, 12);
    ticks(4);
    check("fadeout_level8", level_o, 8);
    pix(0, 2, 12'h741);
    flush();
    ticks(8);
    check("dark_level", level_o, 0);
    check("dark_busy", fade_busy_o, 0);
    pix(0, 2, 12'h000);
    flush();
    start(0);
    check("dark_fadeout_ignored", fade_busy_o, 0);
    // start coincident with tick: state changes, level does not
    fade_start_i = 1; fade_dir_i = 1; frame_tick_i = 1;
    @(negedge clk);
    fade_start_i = 0; frame_tick_i = 0;
    check("fadein_tick_same_cycle_level", level_o, 0);
    check("fadein_busy", fade_busy_o, 1);
    ticks(1);
    check("fadein_level1", level_o, 1);
    ticks(4);
    check("fadein_level5", level_o, 5);
    pix(0, 2, 12'h420);
    flush();
    // asynchronous reset mid-fade
    #2 rst_n = 0;
    #1;
    check("midfade_rst_level", level_o, 16);
    check("midfade_rst_busy", fade_busy_o, 0);
    check("midfade_rst_rgb", {red_o, green_o, blue_o}, 0);
    check("midfade_rst_valid", pix_valid_o, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    pix(2, 5, 12'hA0A);
    pix(1, 3, 12'h0AA);
    pix(0, 2, 12'h0A0);
    flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
